// File: rtl/btb_predictor.sv
// Branch target buffer with a direct-mapped table indexed by the low PC bits.
//
// Lookup is combinational: pc selects an entry, and a valid entry with a
// matching tag gives a hit. A hit that predicts taken redirects to the
// stored target. Otherwise the prediction is pc+1.
// The resolve stage updates the table through upd_*. inv_all, or reset,
// starts a one-entry-per-cycle sweep that clears every valid bit. ready is
// low until that sweep has finished.
//
// Parameters:
//   WORD_SIZE  width of the PC and target
//   IDX_BITS   index width; the table holds 2**IDX_BITS entries
//
// Ports:
//   clk, reset_n         clock and synchronous active-low reset
//   pc                   fetch PC to look up
//   pred_target          predicted next PC
//   pred_taken           prediction is a redirect
//   hit                  a valid entry with a matching tag exists
//   ready                the sweep is done and the table is usable
//   upd_valid/upd_pc/upd_taken/upd_uncond/upd_target
//                        resolved control-flow update
//   inv_all              invalidate the whole table
//
// Build option:
//   BTB_PRED_COUNTER_EN  when defined, each entry stores a 2-bit saturating
//                        counter and its MSB gives the direction. When not
//                        defined, a hit always predicts taken and a
//                        not-taken update that hits invalidates the entry.

module btb_predictor #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned IDX_BITS  = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] pc,
  output logic [WORD_SIZE-1:0] pred_target,
  output logic                 pred_taken,
  output logic                 hit,
  output logic                 ready,
  input  logic                 upd_valid,
  input  logic [WORD_SIZE-1:0] upd_pc,
  input  logic                 upd_taken,
  input  logic                 upd_uncond,
  input  logic [WORD_SIZE-1:0] upd_target,
  input  logic                 inv_all
);

  localparam int unsigned Entries = 1 << IDX_BITS;
  localparam int unsigned TagW    = WORD_SIZE - IDX_BITS;

  typedef enum logic {StInit, StReady} state_e;

  state_e              state_q, state_d;
  logic [IDX_BITS-1:0] sweep_idx_q, sweep_idx_d;

  logic                 valid_q  [Entries];
  logic [TagW-1:0]      tag_q    [Entries];
  logic [WORD_SIZE-1:0] target_q [Entries];
`ifdef BTB_PRED_COUNTER_EN
  logic [1:0]           ctr_q    [Entries];
  logic [1:0]           ctr_wr;
`endif

  // Sweep FSM
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StInit;
      sweep_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    unique case (state_q)
      StInit: begin
        if (inv_all) begin
          sweep_idx_d = '0;
        end else if (&sweep_idx_q) begin
          state_d     = StReady;
          sweep_idx_d = '0;
        end else begin
          sweep_idx_d = sweep_idx_q + 1'b1;
        end
      end
      StReady: begin
        if (inv_all) begin
          state_d     = StInit;
          sweep_idx_d = '0;
        end
      end
      default: begin
        state_d     = StInit;
        sweep_idx_d = '0;
      end
    endcase
  end

  assign ready = (state_q == StReady);

  // Lookup
  logic [IDX_BITS-1:0] lk_idx;
  logic [TagW-1:0]     lk_tag;

  assign lk_idx = pc[IDX_BITS-1:0];
  assign lk_tag = pc[WORD_SIZE-1:IDX_BITS];
  assign hit    = ready & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);

`ifdef BTB_PRED_COUNTER_EN
  assign pred_taken = hit & ctr_q[lk_idx][1];
`else
  assign pred_taken = hit;
`endif

  assign pred_target = pred_taken ? target_q[lk_idx] : pc + WORD_SIZE'(1);

  // Update decode
  logic [IDX_BITS-1:0] upd_idx;
  logic [TagW-1:0]     upd_tag;
  logic                upd_en, upd_hit, taken_eff;
  logic                alloc, retarget, nt_hit;

  assign upd_idx   = upd_pc[IDX_BITS-1:0];
  assign upd_tag   = upd_pc[WORD_SIZE-1:IDX_BITS];
  // reset_n gating keeps an update from landing while the FSM is being reset
  assign upd_en    = reset_n & upd_valid & ready & ~inv_all;
  assign upd_hit   = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);
  // Unconditional jumps always count as taken.
  assign taken_eff = upd_taken | upd_uncond;

  always_comb begin
    alloc    = 1'b0;
    retarget = 1'b0;
    nt_hit   = 1'b0;
    if (upd_en) begin
      if (!upd_hit)      alloc    = taken_eff;
      else if (taken_eff) retarget = 1'b1;
      else               nt_hit   = 1'b1;
    end
  end

`ifdef BTB_PRED_COUNTER_EN
  always_comb begin
    ctr_wr = ctr_q[upd_idx];
    if (alloc) begin
      ctr_wr = upd_uncond ? 2'b11 : 2'b10;
    end else if (retarget) begin
      if (upd_uncond || ctr_q[upd_idx] == 2'b11) ctr_wr = 2'b11;
      else                                        ctr_wr = ctr_q[upd_idx] + 2'b01;
    end else if (nt_hit) begin
      if (ctr_q[upd_idx] != 2'b00) ctr_wr = ctr_q[upd_idx] - 2'b01;
    end
  end
`endif

  // Table storage. Only the valid bits are cleared, and the sweep clears them,
  // so the payload needs no reset. The sweep and updates never happen in the
  // same cycle, because updates are accepted only in StReady.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      valid_q[sweep_idx_q] <= 1'b0;
    end else if (alloc) begin
      valid_q[upd_idx]  <= 1'b1;
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= upd_target;
    end else if (retarget) begin
      target_q[upd_idx] <= upd_target;
    end
`ifndef BTB_PRED_COUNTER_EN
    else if (nt_hit) begin
      valid_q[upd_idx] <= 1'b0;
    end
`endif
  end

`ifdef BTB_PRED_COUNTER_EN
  always_ff @(posedge clk) begin
    if (alloc || retarget || nt_hit) begin
      ctr_q[upd_idx] <= ctr_wr;
    end
  end
`endif

endmodule
